// File: rtl/scr1_sleep_pkg.sv
// Shared types and widths for the pipeline sleep/wake sequencer.
package scr1_sleep_pkg;

  localparam int unsigned SCR1_SLEEP_IDLE_CNT_W = 4;
  localparam int unsigned SCR1_SLEEP_TO_CNT_W   = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    EXIT  = 2'd3
  } type_scr1_sleep_fsm_e;

endpackage : scr1_sleep_pkg

// File: rtl/scr1_pipe_sleep_ctrl.sv
// WFI sleep/wake sequencer feeding the pipeline clock controller.
// Optional DRAIN timeout enabled by SCR1_SLEEP_DRAIN_TIMEOUT_EN.
module scr1_pipe_sleep_ctrl
  import scr1_sleep_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic wfi_req,
  input  logic mem_idle,
  input  logic irq_pending,
  input  logic dbg_req,
  output logic wfi_stall,
  output logic sleep_pipe,
  output logic wake_pipe,
  output logic wfi_done,
  output logic pipe_asleep,
  output logic wfi_aborted
);

  type_scr1_sleep_fsm_e state, state_next;
  logic [SCR1_SLEEP_IDLE_CNT_W-1:0] idle_cnt, idle_cnt_next;
  logic wake_src;
  logic drain_ok;
  logic done_c;
  logic abort_c;

  assign wake_src = irq_pending | dbg_req;
  assign drain_ok = mem_idle
                  && (idle_cnt == SCR1_SLEEP_IDLE_CNT_W'(DRAIN_CYCLES - 1));

`ifdef SCR1_SLEEP_DRAIN_TIMEOUT_EN
  logic [SCR1_SLEEP_TO_CNT_W-1:0] to_cnt, to_cnt_next;
  logic timeout;

  assign timeout = (to_cnt == SCR1_SLEEP_TO_CNT_W'(DRAIN_TIMEOUT));

  // Cycles spent in DRAIN; zero on the first DRAIN cycle, saturating.
  always_comb begin
    to_cnt_next = '0;
    if (state == DRAIN) begin
      to_cnt_next = (&to_cnt) ? to_cnt : to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_cnt_next;
  end
`else
  logic timeout;
  logic [SCR1_SLEEP_TO_CNT_W-1:0] unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = SCR1_SLEEP_TO_CNT_W'(DRAIN_TIMEOUT);
`endif

  // Consecutive idle cycles while draining, saturating.
  always_comb begin
    idle_cnt_next = '0;
    if ((state == DRAIN) && mem_idle) begin
      idle_cnt_next = (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;
    end
  end

  // Next-state logic; wake beats drain completion beats timeout.
  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    case (state)
      RUN: begin
        if (wfi_req) begin
          if (wake_src) done_c = 1'b1;
          else          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (wake_src) begin
          state_next = EXIT;
        end else if (drain_ok) begin
          state_next = SLEEP;
        end else if (timeout) begin
          state_next = RUN;
          done_c     = 1'b1;
          abort_c    = 1'b1;
        end
      end
      SLEEP: begin
        if (wake_src) state_next = EXIT;
      end
      EXIT: begin
        state_next = RUN;
        done_c     = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      idle_cnt    <= '0;
      wfi_stall   <= 1'b0;
      sleep_pipe  <= 1'b0;
      wake_pipe   <= 1'b0;
      wfi_done    <= 1'b0;
      pipe_asleep <= 1'b0;
      wfi_aborted <= 1'b0;
    end else begin
      state       <= state_next;
      idle_cnt    <= idle_cnt_next;
      wfi_stall   <= (state_next != RUN);
      sleep_pipe  <= (state_next == SLEEP);
      wake_pipe   <= (state_next == EXIT);
      wfi_done    <= done_c;
      pipe_asleep <= (state_next == SLEEP);
      wfi_aborted <= abort_c;
    end
  end

endmodule : scr1_pipe_sleep_ctrl

// File: tb/tb_scr1_pipe_sleep_ctrl.sv
// Directed bench for scr1_pipe_sleep_ctrl (default build, DRAIN_CYCLES=2).
module tb_scr1_pipe_sleep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic wfi_req, mem_idle, irq_pending, dbg_req;
  logic wfi_stall, sleep_pipe, wake_pipe, wfi_done, pipe_asleep, wfi_aborted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scr1_pipe_sleep_ctrl #(.DRAIN_CYCLES(2), .DRAIN_TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .wfi_req    (wfi_req),
    .mem_idle   (mem_idle),
    .irq_pending(irq_pending),
    .dbg_req    (dbg_req),
    .wfi_stall  (wfi_stall),
    .sleep_pipe (sleep_pipe),
    .wake_pipe  (wake_pipe),
    .wfi_done   (wfi_done),
    .pipe_asleep(pipe_asleep),
    .wfi_aborted(wfi_aborted)
  );

  // Output vector: {stall, sleep, wake, done, asleep, aborted}
  localparam logic [5:0] IDLE_O  = 6'b000000;
  localparam logic [5:0] STALL_O = 6'b100000;
  localparam logic [5:0] SLEEP_O = 6'b110010;
  localparam logic [5:0] EXIT_O  = 6'b101000;
  localparam logic [5:0] DONE_O  = 6'b000100;

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {wfi_stall, sleep_pipe, wake_pipe, wfi_done, pipe_asleep, wfi_aborted};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    total++;
    assert ((sleep_pipe & wake_pipe) === 1'b0) else begin
      bad++;
      $error("FAIL %s_excl observed=%b expected=0", tag, sleep_pipe & wake_pipe);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wfi_req = 1'b0; mem_idle = 1'b0; irq_pending = 1'b0; dbg_req = 1'b0;
    tick(); tick();
    check("reset", IDLE_O);
    rst = 1'b0;
    tick();
    check("run_idle", IDLE_O);

    // Basic sleep and irq wake, with irq dropping during EXIT
    wfi_req = 1'b1; mem_idle = 1'b1;
    tick(); wfi_req = 1'b0;
    check("drain_enter", STALL_O);
    tick(); check("drain_cnt1", STALL_O);
    tick(); check("sleep_enter", SLEEP_O);
    tick(); check("sleep_hold", SLEEP_O);
    irq_pending = 1'b1;
    tick(); check("exit_irq", EXIT_O);
    irq_pending = 1'b0;
    tick(); check("done_irq", DONE_O);
    tick(); check("run_after", IDLE_O);

    // WFI with wake already pending acts as a NOP
    irq_pending = 1'b1; wfi_req = 1'b1;
    tick(); wfi_req = 1'b0;
    check("wfi_nop", DONE_O);
    tick(); check("wfi_nop_after", IDLE_O);
    irq_pending = 1'b0;

    // Non-consecutive idle cycles restart the drain count
    wfi_req = 1'b1; mem_idle = 1'b1;
    tick(); wfi_req = 1'b0;
    check("drain2_enter", STALL_O);
    mem_idle = 1'b1; tick(); check("drain2_idle1", STALL_O);
    mem_idle = 1'b0; tick(); check("drain2_busy", STALL_O);
    mem_idle = 1'b1; tick(); check("drain2_idle_a", STALL_O);
    mem_idle = 1'b1; tick(); check("drain2_sleep", SLEEP_O);
    dbg_req = 1'b1;
    tick(); check("exit_dbg", EXIT_O);
    dbg_req = 1'b0;
    tick(); check("done_dbg", DONE_O);

    // Busy memory holds DRAIN; dbg aborts drain via EXIT without sleeping
    mem_idle = 1'b0; wfi_req = 1'b1;
    tick(); wfi_req = 1'b0;
    check("drain3_enter", STALL_O);
    tick(); check("drain3_wait1", STALL_O);
    wfi_req = 1'b1;
    tick(); wfi_req = 1'b0;
    check("drain3_wfi_ignored", STALL_O);
    tick(); check("drain3_wait3", STALL_O);
    dbg_req = 1'b1;
    tick(); check("drain3_exit", EXIT_O);
    dbg_req = 1'b0;
    tick(); check("drain3_done", DONE_O);
    tick(); check("drain3_run", IDLE_O);

    // Reset while asleep, then a fresh WFI sequence
    wfi_req = 1'b1; mem_idle = 1'b1;
    tick(); wfi_req = 1'b0;
    tick();
    tick(); check("sleep4", SLEEP_O);
    rst = 1'b1;
    tick(); check("rst_in_sleep", IDLE_O);
    rst = 1'b0;
    tick(); check("rst_run", IDLE_O);
    wfi_req = 1'b1;
    tick(); wfi_req = 1'b0;
    check("post_rst_drain", STALL_O);
    tick(); check("post_rst_drain1", STALL_O);
    tick(); check("post_rst_sleep", SLEEP_O);
    irq_pending = 1'b1;
    tick(); check("post_rst_exit", EXIT_O);
    irq_pending = 1'b0;
    tick(); check("post_rst_done", DONE_O);
    tick(); check("final_run", IDLE_O);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scr1_pipe_sleep_ctrl
